branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Execute-stage consumer of the B-type decode fields (cmp_op, immediate).
//   Turns the ALU compare result into a taken/not-taken decision and computes the target pc+imm.
//   On a taken branch it drives a redirect handshake to fetch, then flushes the younger
//   pipeline stages. Prediction is static not-taken; the unit also keeps a taken-branch counter.
// PARAMETERS
//   FLUSH_CYCLES  2   cycles flush stays high after the redirect handshake completes (0..15)
//   CNT_W         16  width of the saturating taken-branch counter
// PORTS
//   clk             in   1      clock, rising edge
//   rst             in   1      synchronous reset, active-high
//   in_valid        in   1      branch op presented this cycle
//   in_ready        out  1      unit can accept a branch (IDLE only)
//   pc              in   32     address of the branch instruction
//   immediate       in   32     sign-extended B-immediate (bit0 = 0)
//   cmp_op          in   3      `ALU_CMP_* code from the B decoder
//   alu_result      in   32     ALU output for the paired alu_op (XOR/SLT/SLTU)
//   branch_done     out  1      1-cycle pulse: resolution result valid
//   branch_taken    out  1      decision, qualified by branch_done
//   misalign_exc    out  1      1-cycle pulse: taken target not 4-byte aligned
//   redirect_valid  out  1      redirect request to fetch
//   redirect_ready  in   1      fetch accepts the redirect
//   redirect_pc     out  32     target address, held stable while redirect_valid
//   flush           out  1      kill younger stages
//   taken_cnt       out  CNT_W  taken branches that produced a redirect, saturating
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except in_ready=1; taken_cnt=0; redirect_pc=0.
//     rst wins over every event, including a redirect mid-handshake.
//   Decision (combinational in IDLE):
//     EQ  -> alu_result==0       NE  -> alu_result!=0
//     LT  -> alu_result[0]==1    GE  -> alu_result[0]==0
//     LTU -> alu_result[0]==1    GEU -> alu_result[0]==0
//     NOP / any other code -> not taken.
//   Target = pc + immediate, mod 2^32, wrap-around permitted. Registered on acceptance.
//   FSM (IDLE, REDIRECT, FLUSH):
//     IDLE: in_ready=1. Accept on in_valid. Next cycle branch_done=1, branch_taken=decision.
//       - Not taken: stay IDLE.
//       - Taken with target[1:0]!=0: misalign_exc=1 in the same cycle as branch_done.
//         No redirect, no counter increment; stay IDLE.
//       - Taken and aligned: enter REDIRECT; redirect_valid rises together with branch_done.
//     REDIRECT: in_ready=0, redirect_valid=1, flush=1, redirect_pc held.
//       - On redirect_valid & redirect_ready: taken_cnt+1, saturating at all-ones.
//         Go to FLUSH with cnt=FLUSH_CYCLES, or to IDLE when FLUSH_CYCLES==0.
//     FLUSH: in_ready=0, flush=1. cnt decrements each cycle; leave for IDLE when cnt==1.
//   Latency: accept cycle N -> branch_done N+1 -> redirect_valid from N+1.
//     Earliest next accept is N+1 (not taken) or 1+FLUSH_CYCLES cycles after the handshake.
//   in_valid while in_ready=0 is ignored and not stored; upstream must hold the op.
//   Counter at all-ones: a taken redirect leaves it unchanged.
// TESTING
//   EQ, alu_result=0, pc=0x100, imm=0x20 -> done@+1, taken=1, redirect_pc=0x120, taken_cnt=1
//   NE, alu_result=0 -> done=1, taken=0, no redirect_valid, no flush, in_ready stays 1
//   BLT, pc=0xFFFF_FFF0, imm=0x20, alu_result=1 -> redirect_pc=0x0000_0010 (wrap)
//   Taken target 0x102 -> misalign_exc with done, no redirect, taken_cnt unchanged
//   redirect_ready held 0 for 5 cycles then 1 -> redirect_pc stable throughout;
//     flush high for 5+FLUSH_CYCLES(2) cycles; then in_ready=1
//   rst during REDIRECT -> next cycle IDLE, redirect_valid=0, flush=0, taken_cnt=0;
//     CNT_W=2 with 4 taken redirects -> taken_cnt stays 3

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves B-type branches, drives the fetch redirect handshake and younger-stage flush.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc,
  input  logic [31:0]      immediate,
  input  logic [2:0]       cmp_op,
  input  logic [31:0]      alu_result,
  output logic             branch_done,
  output logic             branch_taken,
  output logic             misalign_exc,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);
  localparam logic [1:0] IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2;
  localparam logic [2:0] CMP_EQ = 3'd1, CMP_NE = 3'd2, CMP_LT = 3'd3, CMP_GE = 3'd4, CMP_LTU = 3'd5, CMP_GEU = 3'd6;
  logic [1:0] state;
  logic [3:0] cnt;
  logic decision, accept;
  logic [31:0] target;
  always_comb begin
    target = pc + immediate;
    decision = (cmp_op == CMP_EQ) ? (alu_result == 32'd0) :
               (cmp_op == CMP_NE) ? (alu_result != 32'd0) :
               (cmp_op == CMP_LT || cmp_op == CMP_LTU) ? alu_result[0] :
               (cmp_op == CMP_GE || cmp_op == CMP_GEU) ? !alu_result[0] : 1'b0;
  end
  assign in_ready = state == IDLE;
  assign accept = in_ready && in_valid;
  assign redirect_valid = state == REDIRECT;
  assign flush = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      branch_done <= 1'b0;
      branch_taken <= 1'b0;
      misalign_exc <= 1'b0;
      redirect_pc <= '0;
      taken_cnt <= '0;
    end else begin
      branch_done <= accept;
      misalign_exc <= accept && decision && (target[1:0] != 2'b00);
      if (accept) begin
        branch_taken <= decision;
        redirect_pc <= target;
      end
      if (accept && decision && target[1:0] == 2'b00) state <= REDIRECT;
      else if (state == REDIRECT && redirect_ready) begin
        taken_cnt <= &taken_cnt ? taken_cnt : taken_cnt + 1'b1;
        state <= (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
        cnt <= 4'(FLUSH_CYCLES);
      end else if (state == FLUSH) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus checked against a cycle-level behavioural model plus literal expectations.
module tb_branch_resolve_unit;
  localparam int FC = 2;
  logic clk = 0, rst = 1, in_valid = 0, redirect_ready = 1;
  logic [31:0] pc = 0, immediate = 0, alu_result = 0;
  logic [2:0] cmp_op = 0;
  logic in_ready, branch_done, branch_taken, misalign_exc, redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] taken_cnt;
  logic b_in_ready, b_done, b_taken, b_mis, b_rv, b_flush;
  logic [31:0] b_rpc;
  logic [1:0] b_taken_cnt;
  int n_checks = 0, n_fail = 0;
  int m_mode, m_left, m_cnt;
  bit m_done, m_taken, m_mis;
  logic [31:0] m_rpc, m_t;
  int fc;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .immediate(immediate),
    .cmp_op(cmp_op), .alu_result(alu_result), .branch_done(branch_done), .branch_taken(branch_taken),
    .misalign_exc(misalign_exc), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .taken_cnt(taken_cnt));

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .pc(pc), .immediate(immediate),
    .cmp_op(cmp_op), .alu_result(alu_result), .branch_done(b_done), .branch_taken(b_taken),
    .misalign_exc(b_mis), .redirect_valid(b_rv), .redirect_ready(redirect_ready),
    .redirect_pc(b_rpc), .flush(b_flush), .taken_cnt(b_taken_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit decide(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd1: return a == 0;
      3'd2: return a != 0;
      3'd3, 3'd5: return a[0];
      3'd4, 3'd6: return !a[0];
      default: return 0;
    endcase
  endfunction

  // Model: mode 0 idle, 1 waiting for fetch, 2 flushing with m_left cycles to go.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_cnt = 0; m_done = 0; m_taken = 0; m_mis = 0; m_rpc = 0;
    end else begin
      m_done = 0;
      m_mis = 0;
      if (m_mode == 0) begin
        if (in_valid) begin
          m_t = pc + immediate;
          m_done = 1;
          m_taken = decide(cmp_op, alu_result);
          m_rpc = m_t;
          if (m_taken && m_t % 4 != 0) m_mis = 1;
          else if (m_taken) m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (redirect_ready) begin
          m_cnt++;
          m_left = FC;
          m_mode = (FC > 0) ? 2 : 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_mode == 0);
    check("redirect_valid", redirect_valid, m_mode == 1);
    check("flush", flush, m_mode != 0);
    check("branch_done", branch_done, m_done);
    check("misalign_exc", misalign_exc, m_mis);
    check("redirect_pc", redirect_pc, m_rpc);
    check("taken_cnt", taken_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    check("small_taken_cnt", b_taken_cnt, (m_cnt > 3) ? 3 : m_cnt);
    check("small_flush", b_flush, m_mode != 0);
    if (m_done) check("branch_taken", branch_taken, m_taken);
  end

  task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] p, input logic [31:0] i);
    @(negedge clk);
    cmp_op = c; alu_result = a; pc = p; immediate = i; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    check("idle_wait", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    rst = 0;
    op(3'd1, 32'd0, 32'h100, 32'h20);
    check("eq_done", branch_done, 1);
    check("eq_taken", branch_taken, 1);
    check("eq_rv", redirect_valid, 1);
    check("eq_target", redirect_pc, 32'h120);
    @(negedge clk);
    check("eq_cnt", taken_cnt, 1);
    check("eq_flush", flush, 1);
    wait_idle();
    op(3'd2, 32'd0, 32'h200, 32'h8);
    check("ne_done", branch_done, 1);
    check("ne_taken", branch_taken, 0);
    check("ne_rv", redirect_valid, 0);
    check("ne_flush", flush, 0);
    check("ne_ready", in_ready, 1);
    op(3'd3, 32'd1, 32'hFFFF_FFF0, 32'h20);
    check("wrap_target", redirect_pc, 32'h10);
    wait_idle();
    op(3'd1, 32'd0, 32'h100, 32'h2);
    check("mis_exc", misalign_exc, 1);
    check("mis_done", branch_done, 1);
    check("mis_rv", redirect_valid, 0);
    @(negedge clk);
    check("mis_cnt", taken_cnt, 2);
    redirect_ready = 0;
    op(3'd6, 32'd0, 32'h2000, 32'h40);
    fc = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush) fc++;
      if (redirect_valid) check("stall_pc_stable", redirect_pc, 32'h2040);
      if (in_ready) break;
      cmp_op = 3'd1; alu_result = 0; pc = 32'h3000; immediate = 32'h4;
      in_valid = (i >= 1 && i <= 3);
      if (i == 4) redirect_ready = 1;
      @(negedge clk);
    end
    in_valid = 0;
    check("stall_flush_cycles", fc, 5 + FC);
    check("stall_cnt", taken_cnt, 3);
    op(3'd4, 32'd1, 32'h400, 32'h10);
    op(3'd5, 32'd1, 32'h400, 32'h10);
    wait_idle();
    op(3'd0, 32'd0, 32'h400, 32'h10);
    op(3'd7, 32'd0, 32'h400, 32'h10);
    op(3'd6, 32'd0, 32'h400, 32'h10);
    wait_idle();
    check("wide_cnt", taken_cnt, 5);
    check("sat_cnt", b_taken_cnt, 3);
    redirect_ready = 0;
    op(3'd1, 32'd0, 32'h500, 32'h10);
    check("pre_rst_rv", redirect_valid, 1);
    rst = 1;
    @(negedge clk);
    check("mid_rst_rv", redirect_valid, 0);
    check("mid_rst_flush", flush, 0);
    check("mid_rst_cnt", taken_cnt, 0);
    check("mid_rst_ready", in_ready, 1);
    rst = 0;
    redirect_ready = 1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
